// File: rtl/creg_port_sched_pkg.sv
// Shared constants for the concurrent-register port scheduler: port count,
// operation encodings, requester-count limits and a one-hot index helper.
package creg_port_sched_pkg;

    localparam int unsigned NPORTS   = 5;
    localparam int unsigned NREQ_MIN = 2;
    localparam int unsigned NREQ_MAX = 16;

    typedef enum logic {
        OP_ADD   = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic logic [3:0] onehot_idx(input logic [NREQ_MAX-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/creg_port_sched_if.sv
// Request/grant bus plus the five write/read port pairs of the concurrent register.
interface creg_port_sched_if #(
    parameter int unsigned width = 32,
    parameter int unsigned nreq  = 8
);
    logic [nreq-1:0]       REQ;
    logic [nreq-1:0]       OP;
    logic [nreq*width-1:0] OPND;
    logic [nreq-1:0]       GNT;
    logic                  EN_0, EN_1, EN_2, EN_3, EN_4;
    logic [width-1:0]      D_IN_0, D_IN_1, D_IN_2, D_IN_3, D_IN_4;
    logic [width-1:0]      Q_OUT_0, Q_OUT_1, Q_OUT_2, Q_OUT_3, Q_OUT_4;

    modport master (
        output REQ, OP, OPND,
        output Q_OUT_0, Q_OUT_1, Q_OUT_2, Q_OUT_3, Q_OUT_4,
        input  GNT,
        input  EN_0, EN_1, EN_2, EN_3, EN_4,
        input  D_IN_0, D_IN_1, D_IN_2, D_IN_3, D_IN_4
    );

    modport slave (
        input  REQ, OP, OPND,
        input  Q_OUT_0, Q_OUT_1, Q_OUT_2, Q_OUT_3, Q_OUT_4,
        output GNT,
        output EN_0, EN_1, EN_2, EN_3, EN_4,
        output D_IN_0, D_IN_1, D_IN_2, D_IN_3, D_IN_4
    );
endinterface

// File: rtl/creg_sched_pick.sv
// Rotating finder: scans req starting at ptr and returns the first NPORTS
// set requesters as one-hot selections, in scan order, with a valid bit each.
module creg_sched_pick
    import creg_port_sched_pkg::*;
#(
    parameter int unsigned nreq = 8,
    localparam int unsigned PTRW = $clog2(nreq)
) (
    input  logic [nreq-1:0]             req,
    input  logic [PTRW-1:0]             ptr,
    output logic [NPORTS-1:0][nreq-1:0] sel,
    output logic [NPORTS-1:0]           vld
);

    always_comb begin
        logic [2:0]      found;
        logic [PTRW-1:0] idx;
        int unsigned     sum;
        sel   = '0;
        vld   = '0;
        found = '0;
        idx   = '0;
        for (int unsigned i = 0; i < nreq; i++) begin
            sum = 32'(ptr) + i;
            if (sum >= nreq) sum = sum - nreq;
            idx = PTRW'(sum);
            if (req[idx] && (found < 3'(NPORTS))) begin
                sel[found][idx] = 1'b1;
                vld[found]      = 1'b1;
                found           = found + 3'd1;
            end
        end
    end

endmodule

// File: rtl/creg_port_sched.sv
// Round-robin binder of up to nreq add/overwrite requests onto the five ports
// of a concurrent register. Optional CREG_SCHED_STATS_EN adds grant/deny counters.
module creg_port_sched
    import creg_port_sched_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned nreq  = 8
) (
    input  logic CLK,
    input  logic RST,
    creg_port_sched_if.slave bus
`ifdef CREG_SCHED_STATS_EN
    ,
    output logic [31:0] GRANT_CNT,
    output logic [31:0] DENY_CNT
`endif
);

    localparam int unsigned PTRW = $clog2(nreq);

    logic [PTRW-1:0]             ptr_q, ptr_d;
    logic [NPORTS-1:0][nreq-1:0] sel;
    logic [NPORTS-1:0]           vld;
    logic [width-1:0]            q_out [NPORTS];
    logic [width-1:0]            d_in  [NPORTS];
    logic [NPORTS-1:0]           en;
    logic [nreq-1:0]             gnt;

    assign q_out[0] = bus.Q_OUT_0;
    assign q_out[1] = bus.Q_OUT_1;
    assign q_out[2] = bus.Q_OUT_2;
    assign q_out[3] = bus.Q_OUT_3;
    assign q_out[4] = bus.Q_OUT_4;

    creg_sched_pick #(.nreq(nreq)) u_pick (
        .req (bus.REQ),
        .ptr (ptr_q),
        .sel (sel),
        .vld (vld)
    );

    // Port k carries its bound requester's operation; RST low forces all outputs idle.
    always_comb begin
        logic [width-1:0] opnd;
        logic             op;
        gnt  = '0;
        en   = '0;
        opnd = '0;
        op   = 1'b0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            d_in[k] = '0;
            opnd    = '0;
            op      = 1'b0;
            for (int unsigned i = 0; i < nreq; i++) begin
                if (sel[k][i]) begin
                    opnd = opnd | bus.OPND[i*width +: width];
                    op   = op | bus.OP[i];
                end
            end
            if (vld[k] && RST) begin
                en[k]   = 1'b1;
                d_in[k] = (op_e'(op) == OP_WRITE) ? opnd : q_out[k] + opnd;
                gnt     = gnt | sel[k];
            end
        end
    end

    always_comb begin
        logic [3:0]  last;
        int unsigned nxt;
        last = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (vld[k]) last = onehot_idx(NREQ_MAX'(sel[k]));
        end
        nxt = 32'(last) + 32'd1;
        if (nxt >= nreq) nxt = 0;
        ptr_d = (|vld) ? PTRW'(nxt) : ptr_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign bus.GNT    = gnt;
    assign bus.EN_0   = en[0];
    assign bus.EN_1   = en[1];
    assign bus.EN_2   = en[2];
    assign bus.EN_3   = en[3];
    assign bus.EN_4   = en[4];
    assign bus.D_IN_0 = d_in[0];
    assign bus.D_IN_1 = d_in[1];
    assign bus.D_IN_2 = d_in[2];
    assign bus.D_IN_3 = d_in[3];
    assign bus.D_IN_4 = d_in[4];

`ifdef CREG_SCHED_STATS_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] deny_cnt_q, deny_cnt_d;

    // Deny counts every requester left waiting this cycle; both counters saturate.
    always_comb begin
        logic [32:0] g_sum, d_sum;
        logic [5:0]  n_req, n_gnt;
        n_req       = 6'($countones(bus.REQ));
        n_gnt       = 6'($countones(gnt));
        g_sum       = {1'b0, grant_cnt_q} + 33'(n_gnt);
        d_sum       = {1'b0, deny_cnt_q} + 33'(n_req - n_gnt);
        grant_cnt_d = g_sum[32] ? '1 : g_sum[31:0];
        deny_cnt_d  = d_sum[32] ? '1 : d_sum[31:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            grant_cnt_q <= '0;
            deny_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            deny_cnt_q  <= deny_cnt_d;
        end
    end

    assign GRANT_CNT = grant_cnt_q;
    assign DENY_CNT  = deny_cnt_q;
`endif

endmodule

// File: tb/tb_creg_port_sched.sv
// Bench for creg_port_sched: directed cases plus randomized traffic against a
// queue-based scan model that also plays the concurrent register chain.
module tb_creg_port_sched;
    import creg_port_sched_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned N = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    creg_port_sched_if #(.width(W), .nreq(N)) bus ();

`ifdef CREG_SCHED_STATS_EN
    logic [31:0] grant_cnt, deny_cnt;
`endif

    creg_port_sched #(.width(W), .nreq(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus)
`ifdef CREG_SCHED_STATS_EN
        ,
        .GRANT_CNT (grant_cnt),
        .DENY_CNT  (deny_cnt)
`endif
    );

    logic [4:0]   dut_en;
    logic [W-1:0] dut_d [5];
    assign dut_en   = {bus.EN_4, bus.EN_3, bus.EN_2, bus.EN_1, bus.EN_0};
    assign dut_d[0] = bus.D_IN_0;
    assign dut_d[1] = bus.D_IN_1;
    assign dut_d[2] = bus.D_IN_2;
    assign dut_d[3] = bus.D_IN_3;
    assign dut_d[4] = bus.D_IN_4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] s_req, s_op;
    logic [W-1:0] s_opnd [N];

    int unsigned m_ptr;
    logic [W-1:0] m_reg, m_next;
    logic [W-1:0] m_q [5];
    int unsigned m_bound [$];
    logic [N-1:0] e_gnt;
    logic [4:0]   e_en;
    logic [W-1:0] e_d [5];

    // Model: bind the first five requesters in scan order, chain the register through the ports.
    task automatic apply();
        int unsigned idx;
        logic [W-1:0] v;
        m_bound.delete();
        for (int unsigned i = 0; i < N; i++) begin
            idx = (m_ptr + i) % N;
            if (s_req[idx] && m_bound.size() < 5) m_bound.push_back(idx);
        end
        e_gnt = '0;
        e_en  = '0;
        v     = m_reg;
        for (int unsigned k = 0; k < 5; k++) begin
            m_q[k] = v;
            e_d[k] = '0;
            if (k < m_bound.size()) begin
                idx      = m_bound[k];
                e_gnt[idx] = 1'b1;
                e_en[k]  = 1'b1;
                e_d[k]   = s_op[idx] ? s_opnd[idx] : v + s_opnd[idx];
                v        = e_d[k];
            end
        end
        m_next   = v;
        bus.REQ  = s_req;
        bus.OP   = s_op;
        for (int unsigned i = 0; i < N; i++) bus.OPND[i*W +: W] = s_opnd[i];
        bus.Q_OUT_0 = m_q[0];
        bus.Q_OUT_1 = m_q[1];
        bus.Q_OUT_2 = m_q[2];
        bus.Q_OUT_3 = m_q[3];
        bus.Q_OUT_4 = m_q[4];
        #1;
    endtask

    task automatic clock_edge();
        @(posedge CLK);
        if (m_bound.size() > 0) m_ptr = (m_bound[m_bound.size()-1] + 1) % N;
        m_reg = m_next;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST   = 1'b0;
        s_req = '0;
        apply();
        @(negedge CLK);
        RST   = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        s_req = 8'b0000_0110;
        s_op  = '0;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = W'(i + 1);
        apply();
        clock_edge();
        #2;
        RST   = 1'b0;
        s_req = '1;
        apply();
        n_cmp++;
        if (bus.GNT !== '0) begin n_bad++; $display("FAIL reset_gnt: got %h want 00", bus.GNT); end
        n_cmp++;
        if (dut_en !== '0) begin n_bad++; $display("FAIL reset_en: got %b want 00000", dut_en); end
        for (int unsigned k = 0; k < 5; k++) begin
            n_cmp++;
            if (dut_d[k] !== '0) begin n_bad++; $display("FAIL reset_d%0d: got %h want 00", k, dut_d[k]); end
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (bus.GNT !== '0) begin n_bad++; $display("FAIL reset_gnt_edge: got %h want 00", bus.GNT); end
        @(negedge CLK);
        RST   = 1'b1;
        m_ptr = 0;
        s_req = 8'b1100_0001;
        s_op  = '1;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = W'(i + 20);
        apply();
        n_cmp++;
        if (bus.GNT !== 8'hC1) begin n_bad++; $display("FAIL reset_resume_gnt: got %h want c1", bus.GNT); end
        n_cmp++;
        if (dut_d[0] !== 8'd20) begin n_bad++; $display("FAIL reset_resume_ptr0: got %0d want 20", dut_d[0]); end
        clock_edge();
    endtask

    task automatic test_three_adds();
        do_reset();
        m_reg = 8'd10;
        s_req = 8'b0000_1011;
        s_op  = '0;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = 8'd1;
        apply();
        n_cmp++;
        if (bus.GNT !== 8'b0000_1011) begin n_bad++; $display("FAIL adds_gnt: got %b want 00001011", bus.GNT); end
        n_cmp++;
        if (dut_en !== 5'b00111) begin n_bad++; $display("FAIL adds_en: got %b want 00111", dut_en); end
        n_cmp++;
        if (dut_d[0] !== 8'd11) begin n_bad++; $display("FAIL adds_d0: got %0d want 11", dut_d[0]); end
        n_cmp++;
        if (dut_d[1] !== 8'd12) begin n_bad++; $display("FAIL adds_d1: got %0d want 12", dut_d[1]); end
        n_cmp++;
        if (dut_d[2] !== 8'd13) begin n_bad++; $display("FAIL adds_d2: got %0d want 13", dut_d[2]); end
        n_cmp++;
        if (dut_d[3] !== 8'd0) begin n_bad++; $display("FAIL adds_d3_idle: got %0d want 0", dut_d[3]); end
        clock_edge();
        s_req = 8'b0001_0001;
        s_op  = '1;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = W'(i + 40);
        apply();
        n_cmp++;
        if (dut_d[0] !== 8'd44) begin n_bad++; $display("FAIL adds_ptr4_d0: got %0d want 44", dut_d[0]); end
        n_cmp++;
        if (dut_d[1] !== 8'd40) begin n_bad++; $display("FAIL adds_ptr4_d1: got %0d want 40", dut_d[1]); end
        clock_edge();
    endtask

    task automatic test_overflow();
        do_reset();
        s_req = 8'hFF;
        s_op  = '1;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = W'(i + 60);
        apply();
        n_cmp++;
        if (bus.GNT !== 8'h1F) begin n_bad++; $display("FAIL ovf_gnt1: got %h want 1f", bus.GNT); end
        n_cmp++;
        if (dut_d[4] !== 8'd64) begin n_bad++; $display("FAIL ovf_d4: got %0d want 64", dut_d[4]); end
        clock_edge();
        s_req = 8'hE1;
        apply();
        n_cmp++;
        if (bus.GNT !== 8'hE1) begin n_bad++; $display("FAIL ovf_gnt2: got %h want e1", bus.GNT); end
        n_cmp++;
        if (dut_d[0] !== 8'd65) begin n_bad++; $display("FAIL ovf_ptr5_d0: got %0d want 65", dut_d[0]); end
        n_cmp++;
        if (dut_d[3] !== 8'd60) begin n_bad++; $display("FAIL ovf_wrap_d3: got %0d want 60", dut_d[3]); end
        clock_edge();
    endtask

    task automatic test_mixed();
        do_reset();
        m_reg = 8'd37;
        s_req = 8'b0001_0100;
        s_op  = '0;
        s_op[2] = 1'b1;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = 8'd9;
        s_opnd[2] = 8'd100;
        s_opnd[4] = 8'd5;
        apply();
        n_cmp++;
        if (dut_d[0] !== 8'd100) begin n_bad++; $display("FAIL mixed_d0: got %0d want 100", dut_d[0]); end
        n_cmp++;
        if (dut_d[1] !== 8'd105) begin n_bad++; $display("FAIL mixed_d1: got %0d want 105", dut_d[1]); end
        n_cmp++;
        if (dut_en !== 5'b00011) begin n_bad++; $display("FAIL mixed_en: got %b want 00011", dut_en); end
        clock_edge();
    endtask

    task automatic test_wrap();
        do_reset();
        m_reg = 8'hFF;
        s_req = 8'b0000_0001;
        s_op  = '0;
        s_opnd[0] = 8'd2;
        apply();
        n_cmp++;
        if (dut_d[0] !== 8'h01) begin n_bad++; $display("FAIL wrap_d0: got %h want 01", dut_d[0]); end
        clock_edge();
    endtask

    task automatic test_random();
        int unsigned age [N];
        do_reset();
        m_reg = W'($urandom);
        s_req = '0;
        for (int unsigned i = 0; i < N; i++) age[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!s_req[i]) begin
                    if ($urandom_range(2, 0) != 0) begin
                        s_req[i]  = 1'b1;
                        s_op[i]   = $urandom_range(1, 0) == 1;
                        s_opnd[i] = W'($urandom);
                        age[i]    = 0;
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    s_req[i] = 1'b0;
                end
            end
            apply();
            n_cmp++;
            if (bus.GNT !== e_gnt) begin n_bad++; $display("FAIL rnd_gnt c%0d: got %h want %h", cyc, bus.GNT, e_gnt); end
            n_cmp++;
            if (dut_en !== e_en) begin n_bad++; $display("FAIL rnd_en c%0d: got %b want %b", cyc, dut_en, e_en); end
            for (int unsigned k = 0; k < 5; k++) begin
                n_cmp++;
                if (dut_d[k] !== e_d[k]) begin n_bad++; $display("FAIL rnd_d%0d c%0d: got %h want %h", k, cyc, dut_d[k], e_d[k]); end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (e_gnt[i]) begin
                    n_cmp++;
                    if (age[i] > 1) begin n_bad++; $display("FAIL rnd_latency r%0d: waited %0d want <=1", i, age[i]); end
                end
            end
            clock_edge();
            for (int unsigned i = 0; i < N; i++) begin
                if (e_gnt[i]) s_req[i] = 1'b0;
                else if (s_req[i]) age[i]++;
            end
        end
    endtask

`ifdef CREG_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        s_req = 8'h7F;
        s_op  = '0;
        apply();
        clock_edge();
        s_req = '0;
        apply();
        n_cmp++;
        if (grant_cnt !== 32'd5) begin n_bad++; $display("FAIL stats_grant: got %0d want 5", grant_cnt); end
        n_cmp++;
        if (deny_cnt !== 32'd2) begin n_bad++; $display("FAIL stats_deny: got %0d want 2", deny_cnt); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST    = 1'b0;
        m_ptr  = 0;
        m_reg  = '0;
        s_req  = '0;
        s_op   = '0;
        for (int unsigned i = 0; i < N; i++) s_opnd[i] = '0;
        apply();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        test_reset();
        test_three_adds();
        test_overflow();
        test_mixed();
        test_wrap();
        test_random();
`ifdef CREG_SCHED_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
